// File: rtl/cpu_cycle_sequencer_pkg.sv
// Shared widths, state encodings and helpers for the multi-cycle sequencer.
// State encodings are exported so trace/debug logic can decode the FSM.
package cpu_cycle_sequencer_pkg;

  localparam int unsigned DATA_WIDTH       = 32;
  localparam int unsigned RETIRED_WIDTH    = 32;
  localparam int unsigned WAIT_COUNT_WIDTH = 8;

  localparam logic [2:0] STATE_FETCH     = 3'd0;
  localparam logic [2:0] STATE_DECODE    = 3'd1;
  localparam logic [2:0] STATE_EXECUTE   = 3'd2;
  localparam logic [2:0] STATE_MEMORY    = 3'd3;
  localparam logic [2:0] STATE_WRITEBACK = 3'd4;
  localparam logic [2:0] STATE_HALTED    = 3'd5;
  localparam logic [2:0] STATE_FAULT     = 3'd6;

  typedef enum logic [2:0] {
    stFetch     = STATE_FETCH,
    stDecode    = STATE_DECODE,
    stExecute   = STATE_EXECUTE,
    stMemory    = STATE_MEMORY,
    stWriteback = STATE_WRITEBACK,
    stHalted    = STATE_HALTED,
    stFault     = STATE_FAULT
  } cycleState_t;

  // States that own the shared memory port and wait on mem_ready.
  function automatic logic isMemoryState(input cycleState_t state);
    return (state == stFetch) || (state == stMemory);
  endfunction

endpackage

// File: rtl/cpu_cycle_sequencer_mem_wait_timer.sv
// Counts consecutive mem_ready-low cycles in a memory-owning state and flags
// a hung access on the TIMEOUT_CYCLES-th wait cycle; a ready always wins.
module cpu_cycle_sequencer_mem_wait_timer
  import cpu_cycle_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [WAIT_COUNT_WIDTH-1:0] WAIT_LIMIT = WAIT_COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [WAIT_COUNT_WIDTH-1:0] waitCount;

  assign timeout = waiting & ~mem_ready & (waitCount == WAIT_LIMIT);

  // Any state change (ready, timeout, or leaving the wait state) restarts the count.
  always_ff @(posedge clk) begin
    if (reset || !waiting || mem_ready || timeout) begin
      waitCount <= '0;
    end else begin
      waitCount <= waitCount + WAIT_COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, writeback,
// arbitrating the single memory port by state and faulting on hung accesses.
module cpu_cycle_sequencer
  import cpu_cycle_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    programCounter,
  input  logic                     ls_req,
  input  logic                     ls_write,
  input  logic [DATA_WIDTH-1:0]    ls_addr,
  input  logic                     rf_wr_req,
  input  logic                     halt_req,
  input  logic                     mem_ready,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_addr,
  output logic                     cir_writeEnable,
  output logic                     pc_writeEnable,
  output logic                     ld_capture,
  output logic                     rf_writeEnable,
  output logic                     halted,
  output logic                     busError,
  output logic [RETIRED_WIDTH-1:0] retired
);

  cycleState_t state;
  cycleState_t nextState;
  logic        timeout;
  logic [RETIRED_WIDTH-1:0] retiredCount;

  cpu_cycle_sequencer_mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) mem_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .waiting  (isMemoryState(state)),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= stFetch;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      stFetch: begin
        if (mem_ready)    nextState = stDecode;
        else if (timeout) nextState = stFault;
      end
      stDecode:    nextState = stExecute;
      stExecute:   nextState = ls_req ? stMemory : stWriteback;
      stMemory: begin
        if (mem_ready)    nextState = stWriteback;
        else if (timeout) nextState = stFault;
      end
      stWriteback: nextState = halt_req ? stHalted : stFetch;
      stHalted:    nextState = stHalted;
      stFault:     nextState = stFault;
      default:     nextState = stFetch;
    endcase
  end

  // Reset overrides every output so a stale response cannot leak a strobe.
  always_comb begin
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    cir_writeEnable = 1'b0;
    pc_writeEnable  = 1'b0;
    ld_capture      = 1'b0;
    rf_writeEnable  = 1'b0;
    halted          = 1'b0;
    busError        = 1'b0;
    if (!reset) begin
      case (state)
        stFetch: begin
          mem_req         = 1'b1;
          mem_addr        = programCounter;
          cir_writeEnable = mem_ready;
        end
        stMemory: begin
          mem_req    = 1'b1;
          mem_we     = ls_write;
          mem_addr   = ls_addr;
          ld_capture = mem_ready & ~ls_write;
        end
        stWriteback: begin
          pc_writeEnable = 1'b1;
          rf_writeEnable = rf_wr_req & ~(ls_req & ls_write);
        end
        stHalted: halted   = 1'b1;
        stFault:  busError = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retiredCount <= '0;
    end else if (state == stWriteback) begin
      retiredCount <= retiredCount + RETIRED_WIDTH'(1);
    end
  end

  assign retired = reset ? '0 : retiredCount;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Self-checking bench for cpu_cycle_sequencer: directed scenarios plus a
// randomized instruction stream checked against a per-instruction timeline model.
module tb_cpu_cycle_sequencer;

  localparam int unsigned TB_TIMEOUT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] programCounter;
  logic        ls_req;
  logic        ls_write;
  logic [31:0] ls_addr;
  logic        rf_wr_req;
  logic        halt_req;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic        cir_writeEnable;
  logic        pc_writeEnable;
  logic        ld_capture;
  logic        rf_writeEnable;
  logic        halted;
  logic        busError;
  logic [31:0] retired;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_cycle_sequencer #(
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .programCounter (programCounter),
    .ls_req         (ls_req),
    .ls_write       (ls_write),
    .ls_addr        (ls_addr),
    .rf_wr_req      (rf_wr_req),
    .halt_req       (halt_req),
    .mem_ready      (mem_ready),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .cir_writeEnable(cir_writeEnable),
    .pc_writeEnable (pc_writeEnable),
    .ld_capture     (ld_capture),
    .rf_writeEnable (rf_writeEnable),
    .halted         (halted),
    .busError       (busError),
    .retired        (retired)
  );

  // Output vector layout: {req, we, cir, pcWe, ld, rfWe, halted, busError, addr}
  function automatic logic [39:0] outs();
    return {mem_req, mem_we, cir_writeEnable, pc_writeEnable, ld_capture,
            rf_writeEnable, halted, busError, mem_addr};
  endfunction

  function automatic logic [39:0] ex(input logic req, input logic we, input logic cir,
                                     input logic pcw, input logic ld, input logic rf,
                                     input logic hl, input logic be, input logic [31:0] addr);
    return {req, we, cir, pcw, ld, rf, hl, be, addr};
  endfunction

  task automatic idleInputs();
    programCounter = '0;
    ls_req = 1'b0; ls_write = 1'b0; ls_addr = '0;
    rf_wr_req = 1'b0; halt_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    idleInputs();
    nextCycle();
    nextCycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idleInputs();
    mem_ready = 1'b1;
    programCounter = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== 40'h0 || retired !== 32'h0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: got %h/%h expected 0/0", i, outs(), retired);
      end
      nextCycle();
    end
    reset = 1'b0;
    mem_ready = 1'b0;
    programCounter = 32'h44;
    @(negedge clk);
    checks++;
    if (outs() !== ex(1, 0, 0, 0, 0, 0, 0, 0, 32'h44) || retired !== 32'h0) begin
      failures++;
      $display("FAIL reset_fetch: got %h/%h expected %h/0", outs(), retired,
               ex(1, 0, 0, 0, 0, 0, 0, 0, 32'h44));
    end
    nextCycle();
  endtask

  task automatic test_nonmem();
    logic [39:0] expv [5];
    doReset();
    programCounter = 32'h200;
    rf_wr_req = 1'b1;
    expv[0] = ex(1, 0, 1, 0, 0, 0, 0, 0, 32'h200);
    expv[1] = '0;
    expv[2] = '0;
    expv[3] = ex(0, 0, 0, 1, 0, 1, 0, 0, 32'h0);
    expv[4] = ex(1, 0, 0, 0, 0, 0, 0, 0, 32'h200);
    for (int c = 0; c < 5; c++) begin
      mem_ready = (c < 4);
      @(negedge clk);
      checks++;
      if (outs() !== expv[c] || retired !== ((c == 4) ? 32'd1 : 32'd0)) begin
        failures++;
        $display("FAIL nonmem cycle %0d: got %h/%0d expected %h/%0d", c, outs(), retired,
                 expv[c], (c == 4) ? 1 : 0);
      end
      nextCycle();
    end
  endtask

  task automatic test_load();
    doReset();
    programCounter = 32'h300;
    ls_req = 1'b1; ls_write = 1'b0; ls_addr = 32'h100; rf_wr_req = 1'b1;
    mem_ready = 1'b1;
    nextCycle();
    mem_ready = 1'b0;
    nextCycle();
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      @(negedge clk);
      checks++;
      if (outs() !== ex(1, 0, 0, 0, i == 2, 0, 0, 0, 32'h100)) begin
        failures++;
        $display("FAIL load_memory wait %0d: got %h expected %h", i, outs(),
                 ex(1, 0, 0, 0, i == 2, 0, 0, 0, 32'h100));
      end
      nextCycle();
    end
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== ex(0, 0, 0, 1, 0, 1, 0, 0, 32'h0)) begin
      failures++;
      $display("FAIL load_writeback: got %h expected %h", outs(), ex(0, 0, 0, 1, 0, 1, 0, 0, 32'h0));
    end
    nextCycle();
  endtask

  task automatic test_store();
    doReset();
    programCounter = 32'h304;
    ls_req = 1'b1; ls_write = 1'b1; ls_addr = 32'h1F0; rf_wr_req = 1'b1;
    mem_ready = 1'b1;
    nextCycle();
    mem_ready = 1'b0;
    nextCycle();
    nextCycle();
    for (int i = 0; i < 2; i++) begin
      mem_ready = (i == 1);
      @(negedge clk);
      checks++;
      if (outs() !== ex(1, 1, 0, 0, 0, 0, 0, 0, 32'h1F0)) begin
        failures++;
        $display("FAIL store_memory wait %0d: got %h expected %h", i, outs(),
                 ex(1, 1, 0, 0, 0, 0, 0, 0, 32'h1F0));
      end
      nextCycle();
    end
    @(negedge clk);
    checks++;
    if (outs() !== ex(0, 0, 0, 1, 0, 0, 0, 0, 32'h0)) begin
      failures++;
      $display("FAIL store_writeback: got %h expected %h", outs(), ex(0, 0, 0, 1, 0, 0, 0, 0, 32'h0));
    end
    nextCycle();
  endtask

  task automatic test_timeout();
    // Fetch stuck low: fault after the third wait cycle, then stays put.
    doReset();
    programCounter = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== ex(1, 0, 0, 0, 0, 0, 0, 0, 32'h40)) begin
        failures++;
        $display("FAIL timeout_fetch_wait %0d: got %h expected %h", i, outs(),
                 ex(1, 0, 0, 0, 0, 0, 0, 0, 32'h40));
      end
      nextCycle();
    end
    for (int i = 0; i < 21; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      ls_req = 1'($urandom_range(0, 1));
      rf_wr_req = 1'b1;
      @(negedge clk);
      checks++;
      if (outs() !== ex(0, 0, 0, 0, 0, 0, 0, 1, 32'h0)) begin
        failures++;
        $display("FAIL timeout_fault_hold %0d: got %h expected %h", i, outs(),
                 ex(0, 0, 0, 0, 0, 0, 0, 1, 32'h0));
      end
      nextCycle();
    end
    // Ready on the limiting wait cycle wins; then a memory-stage timeout.
    doReset();
    programCounter = 32'h48;
    ls_req = 1'b1; ls_write = 1'b1; ls_addr = 32'h77;
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      @(negedge clk);
      checks++;
      if (outs() !== ex(1, 0, i == 2, 0, 0, 0, 0, 0, 32'h48)) begin
        failures++;
        $display("FAIL ready_wins %0d: got %h expected %h", i, outs(),
                 ex(1, 0, i == 2, 0, 0, 0, 0, 0, 32'h48));
      end
      nextCycle();
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== 40'h0) begin
        failures++;
        $display("FAIL ready_wins_decode %0d: got %h expected 0", i, outs());
      end
      nextCycle();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== ((i < 3) ? ex(1, 1, 0, 0, 0, 0, 0, 0, 32'h77) : ex(0, 0, 0, 0, 0, 0, 0, 1, 32'h0))) begin
        failures++;
        $display("FAIL timeout_memory %0d: got %h expected %h", i, outs(),
                 (i < 3) ? ex(1, 1, 0, 0, 0, 0, 0, 0, 32'h77) : ex(0, 0, 0, 0, 0, 0, 0, 1, 32'h0));
      end
      nextCycle();
    end
  endtask

  task automatic test_halt();
    doReset();
    programCounter = 32'h80;
    ls_req = 1'b1; ls_write = 1'b1; ls_addr = 32'h90; halt_req = 1'b1;
    mem_ready = 1'b1;
    nextCycle();
    nextCycle();
    nextCycle();
    @(negedge clk);
    checks++;
    if (outs() !== ex(1, 1, 0, 0, 0, 0, 0, 0, 32'h90)) begin
      failures++;
      $display("FAIL halt_store_memory: got %h expected %h", outs(), ex(1, 1, 0, 0, 0, 0, 0, 0, 32'h90));
    end
    nextCycle();
    @(negedge clk);
    checks++;
    if (outs() !== ex(0, 0, 0, 1, 0, 0, 0, 0, 32'h0)) begin
      failures++;
      $display("FAIL halt_writeback: got %h expected %h", outs(), ex(0, 0, 0, 1, 0, 0, 0, 0, 32'h0));
    end
    nextCycle();
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (outs() !== ex(0, 0, 0, 0, 0, 0, 1, 0, 32'h0) || retired !== 32'd1) begin
        failures++;
        $display("FAIL halted_hold %0d: got %h/%0d expected %h/1", i, outs(), retired,
                 ex(0, 0, 0, 0, 0, 0, 1, 0, 32'h0));
      end
      nextCycle();
    end
    idleInputs();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    programCounter = 32'h10;
    @(negedge clk);
    checks++;
    if (outs() !== ex(1, 0, 0, 0, 0, 0, 0, 0, 32'h10) || retired !== 32'd0) begin
      failures++;
      $display("FAIL halt_reset_clear: got %h/%0d expected %h/0", outs(), retired,
               ex(1, 0, 0, 0, 0, 0, 0, 0, 32'h10));
    end
    nextCycle();
  endtask

  task automatic test_reset_mid_access();
    int cirCount;
    doReset();
    programCounter = 32'h500;
    ls_req = 1'b1; ls_write = 1'b0; ls_addr = 32'h600; rf_wr_req = 1'b1;
    mem_ready = 1'b1;
    nextCycle();
    mem_ready = 1'b0;
    nextCycle();
    nextCycle();
    nextCycle();
    reset = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== 40'h0) begin
        failures++;
        $display("FAIL reset_mid_access %0d: got %h expected 0", i, outs());
      end
      nextCycle();
    end
    reset = 1'b0;
    ls_req = 1'b0;
    cirCount = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (cir_writeEnable === 1'b1) cirCount++;
      nextCycle();
    end
    checks++;
    if (cirCount !== 1) begin
      failures++;
      $display("FAIL stray_ready_cir_count: got %0d expected 1", cirCount);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        lsReq;
    logic        lsWrite;
    logic [31:0] lsAddr;
    logic        rfWr;
    logic        ready;
    logic [39:0] expOuts;
    logic [31:0] expRetired;
  } step_t;

  task automatic test_random_program();
    step_t plan[$];
    step_t s;
    int    retiredModel;
    int    fw;
    int    mw;
    retiredModel = 0;
    for (int n = 0; n < 40; n++) begin
      s.pc      = $urandom;
      s.lsReq   = 1'($urandom_range(0, 1));
      s.lsWrite = 1'($urandom_range(0, 1));
      s.lsAddr  = $urandom;
      s.rfWr    = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, TB_TIMEOUT - 1);
      mw = $urandom_range(0, TB_TIMEOUT - 1);
      s.expRetired = 32'(retiredModel);
      for (int i = 0; i <= fw; i++) begin
        s.ready   = (i == fw);
        s.expOuts = ex(1, 0, s.ready, 0, 0, 0, 0, 0, s.pc);
        plan.push_back(s);
      end
      for (int i = 0; i < 2; i++) begin
        s.ready   = 1'($urandom_range(0, 1));
        s.expOuts = '0;
        plan.push_back(s);
      end
      if (s.lsReq) begin
        for (int i = 0; i <= mw; i++) begin
          s.ready   = (i == mw);
          s.expOuts = ex(1, s.lsWrite, 0, 0, s.ready & ~s.lsWrite, 0, 0, 0, s.lsAddr);
          plan.push_back(s);
        end
      end
      s.ready   = 1'($urandom_range(0, 1));
      s.expOuts = ex(0, 0, 0, 1, 0, s.rfWr & ~(s.lsReq & s.lsWrite), 0, 0, 32'h0);
      plan.push_back(s);
      retiredModel++;
    end
    doReset();
    foreach (plan[k]) begin
      programCounter = plan[k].pc;
      ls_req    = plan[k].lsReq;
      ls_write  = plan[k].lsWrite;
      ls_addr   = plan[k].lsAddr;
      rf_wr_req = plan[k].rfWr;
      mem_ready = plan[k].ready;
      @(negedge clk);
      checks++;
      if (outs() !== plan[k].expOuts || retired !== plan[k].expRetired) begin
        failures++;
        $display("FAIL random_step %0d: got %h/%0d expected %h/%0d", k, outs(), retired,
                 plan[k].expOuts, plan[k].expRetired);
      end
      nextCycle();
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load();
    test_store();
    test_timeout();
    test_halt();
    test_reset_mid_access();
    test_random_program();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_cycle_sequencer.md
# cpu_cycle_sequencer

Multi-cycle control FSM that sequences the instruction fetch controller, register file and the single shared memory port. It steps each instruction through fetch, decode, execute, optional memory access and writeback. It arbitrates the one memory port between instruction fetch and load/store traffic by state, so only one requester is ever active. It generates `cir_writeEnable`/`pc_writeEnable` for the fetch controller and detects hung memory accesses.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles waiting for `mem_ready` in one access before faulting; legal 1..255.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `programCounter`  in  `DATA_WIDTH`  current PC from the fetch controller.
- `ls_req`  in  1  decoded instruction needs memory; valid in EXECUTE.
- `ls_write`  in  1  1 = store, 0 = load; valid with `ls_req`.
- `ls_addr`  in  `DATA_WIDTH`  load/store address; held stable through MEMORY.
- `rf_wr_req`  in  1  decoded instruction writes the register file.
- `halt_req`  in  1  decoded instruction is a halt; sampled in WRITEBACK.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  `DATA_WIDTH`  memory address.
- `cir_writeEnable`  out  1  latch instruction into CIR.
- `pc_writeEnable`  out  1  advance or overwrite PC.
- `ld_capture`  out  1  latch load data.
- `rf_writeEnable`  out  1  register-file write strobe.
- `halted`  out  1  core halted; sticky until reset.
- `busError`  out  1  memory timeout fault; sticky until reset.
- `retired`  out  32  retired-instruction count; wraps at 2^32.

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALTED, FAULT.
- Reset: state FETCH, wait counter 0, `retired` 0. All outputs are forced to 0 while `reset` is high.
- FETCH:
  - Drives `mem_req`=1, `mem_we`=0, `mem_addr`=`programCounter`.
  - When `mem_ready`=1: `cir_writeEnable`=1 in the same cycle, then go to DECODE.
- DECODE: one cycle, no outputs asserted, then go to EXECUTE.
- EXECUTE: one cycle. Go to MEMORY if `ls_req`, otherwise go to WRITEBACK.
- MEMORY:
  - Drives `mem_req`=1, `mem_we`=`ls_write`, `mem_addr`=`ls_addr`.
  - When `mem_ready`=1: `ld_capture`=`~ls_write` in the same cycle, then go to WRITEBACK.
- WRITEBACK:
  - Asserts `pc_writeEnable`=1 and `rf_writeEnable`=`rf_wr_req & ~(ls_req & ls_write)`.
  - `retired` += 1.
  - Next state is HALTED if `halt_req`, otherwise FETCH.
- HALTED: `halted`=1, no further requests; exit only via reset.
- Timeout:
  - The wait counter increments each FETCH/MEMORY cycle with `mem_ready`=0 and clears on state change.
  - When the counter reaches `TIMEOUT_CYCLES` while still waiting, go to FAULT.
- FAULT: `busError`=1, `mem_req`=0, all strobes 0; exit only via reset.
- `mem_ready` outside FETCH/MEMORY is ignored.
- `mem_addr` is 0 when `mem_req`=0.

## Timing
- Control outputs are Moore from the state register, except `cir_writeEnable` and `ld_capture`, which are state AND `mem_ready`.
- `halted` and `busError` are decoded from state; `retired` is registered.
- Minimum latency:
  - Non-memory instruction: 4 cycles (FETCH with immediate ready, DECODE, EXECUTE, WRITEBACK).
  - Load/store: 5 cycles.
  - Each wait cycle adds 1.
- `pc_writeEnable` fires exactly once per instruction, in WRITEBACK. The fetch controller's branch/jump overwrite logic is evaluated in that cycle.
- Timeout: with `mem_ready` stuck low, FAULT is entered on the cycle after the `TIMEOUT_CYCLES`-th consecutive wait cycle.
- A `mem_ready` arriving on the wait cycle that would hit the limit counts as success; ready wins over timeout.
- Reset mid-access: in the cycle after `reset` rises, state is FETCH and `mem_req`=0. Any in-flight memory response is ignored until FETCH issues a new request.
- `halt_req` together with a store: the store completes in MEMORY, then WRITEBACK retires it and halts.

## Structure
- State encodings (3-bit) are localparams added to `globalVariables.v` alongside `DATA_WIDTH`/`INSTRUCTION_WIDTH`, so debug/trace logic can decode state.
- One natural sub-module: `mem_wait_timer`, holding the wait counter and limit compare and producing `timeout`.
- Everything else is a single FSM in `cpu_cycle_sequencer`.

## Test plan
- Reset, then a non-memory op with `mem_ready` high in FETCH:
  - Expect `cir_writeEnable` at cycle 0, `pc_writeEnable` and `rf_writeEnable` at cycle 3, `mem_req` again at cycle 4.
  - `retired`=1.
- Load with `ls_addr`=0x100 and 2 wait cycles in MEMORY:
  - Expect `mem_addr`=0x100 and `mem_we`=0 for 3 cycles.
  - `ld_capture` only on the ready cycle.
  - WRITEBACK next, with `rf_writeEnable`=1.
- Store with `rf_wr_req`=1:
  - Expect `mem_we`=1 in MEMORY.
  - `rf_writeEnable`=0 in WRITEBACK.
- `TIMEOUT_CYCLES`=3 with `mem_ready` held low in FETCH:
  - `busError` rises after 3 wait cycles; `mem_req` drops.
  - Both outputs stay put for 20 more cycles.
  - Repeat with ready on the 3rd wait cycle: no fault.
- `halt_req` in WRITEBACK:
  - `halted`=1 from the next cycle, no further `mem_req`.
  - Reset clears `halted` and `retired` to 0.
- Assert `reset` during a MEMORY wait:
  - Next cycle: FETCH with outputs 0.
  - A stray `mem_ready` in the cycle after reset deasserts produces exactly one `cir_writeEnable` in FETCH.
